// File: rtl/reg_write_arbiter_if.sv
// Request/strobe bundle between control-path masters and reg_write_arbiter.
// The master modport belongs to the requester side; slave is the arbiter.
interface reg_write_arbiter_if #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8
);
   localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      wr_en;
   logic [ADDR_W-1:0]         wr_addr;
   logic [DATA_W-1:0]         wr_data;
   logic [SRC_W-1:0]          wr_src;
   logic                      addr_err;

   modport master (
      output req_valid, req_addr, req_data, req_lock,
      input  req_ready, wr_en, wr_addr, wr_data, wr_src, addr_err
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_lock,
      output req_ready, wr_en, wr_addr, wr_data, wr_src, addr_err
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin share of one register-bank write port; REG_ARB_LOCK_EN adds owner locking.
// Grant is combinational, strobe one cycle after the handshake, 1 write/cycle; losers see ready=0.
module reg_write_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   reg_write_arbiter_if.slave   bus
);
   localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W:0]  REGS_LIM = (ADDR_W+1)'(NUM_REGS);
   localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   gnt_idx;
   logic [SRC_W-1:0]   next_ptr;
   logic               found;
   logic               hs;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] grant;
   logic [ADDR_W-1:0]  addr_sel;
   logic [DATA_W-1:0]  data_sel;
   int                 j;

   logic               wr_en_q;
   logic [ADDR_W-1:0]  wr_addr_q;
   logic [DATA_W-1:0]  wr_data_q;
   logic [SRC_W-1:0]   wr_src_q;
   logic               addr_err_q;

`ifdef REG_ARB_LOCK_EN
   logic               locked;
   logic [SRC_W-1:0]   owner;
   logic               lock_sel;

   // While locked the owner is the only candidate, whether or not it is valid.
   always_comb begin
      elig = '1;
      if (locked) begin
         elig        = '0;
         elig[owner] = 1'b1;
      end
   end

   assign lock_sel = bus.req_lock[gnt_idx];
`else
   assign elig = '1;
   wire unused_lock = ^bus.req_lock;
`endif

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      j       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && bus.req_valid[j] && elig[j]) begin
            found   = 1'b1;
            gnt_idx = SRC_W'(j);
         end
      end
   end

   always_comb begin
      grant = '0;
      if (found && !rst) grant[gnt_idx] = 1'b1;
   end

   assign hs       = found && !rst;
   assign addr_sel = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign data_sel = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
   assign next_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_src_q   <= '0;
         addr_err_q <= 1'b0;
`ifdef REG_ARB_LOCK_EN
         locked     <= 1'b0;
         owner      <= '0;
`endif
      end else begin
         wr_en_q    <= 1'b0;
         addr_err_q <= 1'b0;
         if (hs) begin
            wr_addr_q <= addr_sel;
            wr_data_q <= data_sel;
            wr_src_q  <= gnt_idx;
            // Out-of-range writes are consumed but never reach the bank.
            if ({1'b0, addr_sel} < REGS_LIM) wr_en_q    <= 1'b1;
            else                             addr_err_q <= 1'b1;
`ifdef REG_ARB_LOCK_EN
            if (locked) begin
               if (!lock_sel) begin
                  locked <= 1'b0;
                  rr_ptr <= next_ptr;
               end
            end else begin
               rr_ptr <= next_ptr;
               if (lock_sel) begin
                  locked <= 1'b1;
                  owner  <= gnt_idx;
               end
            end
`else
            rr_ptr <= next_ptr;
`endif
         end
      end
   end

   assign bus.req_ready = grant;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.wr_src    = wr_src_q;
   assign bus.addr_err  = addr_err_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NUM_REQ=4, DATA_W=8, NUM_REGS=6) with a strobe scoreboard.
module tb_reg_write_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] data;
      logic [1:0] src;
      logic       err;
   } exp_t;

   exp_t sbq[$];

   reg_write_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .NUM_REGS(6)) bus ();

   reg_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .NUM_REGS(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Strobe monitor: every wr_en/addr_err pulse must match the oldest expected write.
   always @(negedge clk) begin
      exp_t e;
      if (bus.wr_en || bus.addr_err) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected got en=%b err=%b addr=%0d data=%h src=%0d want no strobe",
                     bus.wr_en, bus.addr_err, bus.wr_addr, bus.wr_data, bus.wr_src);
         end else begin
            e = sbq.pop_front();
            if ({bus.wr_en, bus.addr_err, bus.wr_addr, bus.wr_data, bus.wr_src} !==
                {~e.err, e.err, e.addr, e.data, e.src}) begin
               errors++;
               $display("FAIL strobe got en=%b err=%b addr=%0d data=%h src=%0d want en=%b err=%b addr=%0d data=%h src=%0d",
                        bus.wr_en, bus.addr_err, bus.wr_addr, bus.wr_data, bus.wr_src,
                        ~e.err, e.err, e.addr, e.data, e.src);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, got, want);
      end
   endtask

   // One cycle of stimulus, starting 1 time unit after a rising edge.
   task automatic step(input logic [3:0] v, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] lk, input logic [3:0] exp_rdy, input int src,
                       input bit push, input string nm);
      exp_t e;
      bus.req_valid = v;
      bus.req_addr  = a;
      bus.req_data  = d;
      bus.req_lock  = lk;
      #3;
      chk(nm, 32'(bus.req_ready), 32'(exp_rdy));
      if (push && exp_rdy != 4'b0) begin
         e.addr = a[src*3 +: 3];
         e.data = d[src*8 +: 8];
         e.src  = 2'(src);
         e.err  = (e.addr >= 3'd6);
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   localparam logic [11:0] A_ROT = {3'd3, 3'd2, 3'd1, 3'd0};
   localparam logic [31:0] D_ROT = 32'h44332211;

   initial begin
      rst           = 1'b1;
      bus.req_valid = 4'b1111;
      bus.req_addr  = A_ROT;
      bus.req_data  = D_ROT;
      bus.req_lock  = 4'b0;
      #12;
      chk("reset_ready", 32'(bus.req_ready), 32'h0);
      chk("reset_wr_en", 32'(bus.wr_en), 32'h0);
      chk("reset_wr_addr", 32'(bus.wr_addr), 32'h0);
      chk("reset_wr_data", 32'(bus.wr_data), 32'h0);
      chk("reset_wr_src", 32'(bus.wr_src), 32'h0);
      chk("reset_addr_err", 32'(bus.addr_err), 32'h0);
      bus.req_valid = 4'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single request from requester 1.
      step(4'b0010, {3'd0, 3'd0, 3'd3, 3'd0}, 32'h0000A500, 4'b0, 4'b0010, 1, 1'b1, "single_grant");
      step(4'b0000, 12'd0, 32'd0, 4'b0, 4'b0000, 0, 1'b1, "single_idle");
      chk("single_wr_en_drop", 32'(bus.wr_en), 32'h0);
      chk("single_hold_data", 32'(bus.wr_data), 32'hA5);

      // Full rotation from reset.
      do_reset();
      for (int k = 0; k < 8; k++)
         step(4'b1111, A_ROT, D_ROT + 32'(k), 4'b0, 4'(1 << (k % 4)), k % 4, 1'b1, "rotate");

      // Out-of-range address from requester 2, then wrap 3 -> 0 -> 3.
      step(4'b0100, {3'd0, 3'd7, 3'd0, 3'd0}, 32'h00BE0000, 4'b0, 4'b0100, 2, 1'b1, "addr_err_grant");
      step(4'b1001, {3'd5, 3'd0, 3'd0, 3'd4}, 32'hD00000C0, 4'b0, 4'b1000, 3, 1'b1, "wrap_first");
      step(4'b1001, {3'd5, 3'd0, 3'd0, 3'd4}, 32'hD10000C1, 4'b0, 4'b0001, 0, 1'b1, "wrap_second");
      step(4'b1001, {3'd5, 3'd0, 3'd0, 3'd4}, 32'hD20000C2, 4'b0, 4'b1000, 3, 1'b1, "wrap_third");
      step(4'b0000, 12'd0, 32'd0, 4'b0, 4'b0000, 0, 1'b1, "drain_idle");

      // Reset landing on a pending strobe: it must never be seen.
      step(4'b0010, {3'd0, 3'd0, 3'd5, 3'd0}, 32'h00007700, 4'b0, 4'b0010, 1, 1'b0, "pre_reset_grant");
      bus.req_valid = 4'b0;
      rst = 1'b1;
      #1;
      chk("mid_reset_wr_en", 32'(bus.wr_en), 32'h0);
      chk("mid_reset_wr_addr", 32'(bus.wr_addr), 32'h0);
      chk("mid_reset_wr_data", 32'(bus.wr_data), 32'h0);
      chk("mid_reset_wr_src", 32'(bus.wr_src), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(4'b1111, A_ROT, D_ROT, 4'b0, 4'b0001, 0, 1'b1, "post_reset_ptr");
      step(4'b0000, 12'd0, 32'd0, 4'b0, 4'b0000, 0, 1'b1, "drain_idle2");

`ifdef REG_ARB_LOCK_EN
      do_reset();
      step(4'b1111, {3'd5, 3'd4, 3'd0, 3'd1}, 32'h40302010, 4'b0000, 4'b0001, 0, 1'b1, "lock_pre");
      step(4'b1111, {3'd5, 3'd4, 3'd0, 3'd1}, 32'h40302111, 4'b0010, 4'b0010, 1, 1'b1, "lock_take");
      step(4'b1111, {3'd5, 3'd4, 3'd1, 3'd1}, 32'h40302212, 4'b0010, 4'b0010, 1, 1'b1, "lock_hold1");
      step(4'b1101, {3'd5, 3'd4, 3'd1, 3'd1}, 32'h40302313, 4'b0010, 4'b0000, 1, 1'b1, "lock_owner_idle");
      step(4'b1111, {3'd5, 3'd4, 3'd2, 3'd1}, 32'h40302414, 4'b0010, 4'b0010, 1, 1'b1, "lock_hold2");
      step(4'b1111, {3'd5, 3'd4, 3'd3, 3'd1}, 32'h40302515, 4'b0000, 4'b0010, 1, 1'b1, "lock_release");
      step(4'b1111, {3'd5, 3'd4, 3'd3, 3'd1}, 32'h40302616, 4'b0000, 4'b0100, 2, 1'b1, "lock_after");
      step(4'b0000, 12'd0, 32'd0, 4'b0, 4'b0000, 0, 1'b1, "drain_idle3");
`endif

      @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of a bank of enable-loaded registers among NUM_REQ requesters.
- Each requester presents a valid/ready write request (address plus data).
- The arbiter grants one request per cycle and drives a registered wr_en/wr_addr/wr_data strobe into the register bank.
- Sits between the control-path masters (CPU bus slave, DMA, debug) and the configuration register bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, register data width.
- NUM_REGS, 8, number of registers in the target bank (need not be a power of 2).
- ADDR_W, $clog2(NUM_REGS) (min 1), write address width; derived, not overridden.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, NUM_REQ, per-requester write request.
- req_addr, in, NUM_REQ*ADDR_W, packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data, in, NUM_REQ*DATA_W, packed write data; requester i uses slice [i*DATA_W +: DATA_W].
- req_lock, in, NUM_REQ, lock request; used only with REG_ARB_LOCK_EN.
- req_ready, out, NUM_REQ, one-hot-or-zero grant; handshake on valid && ready.
- wr_en, out, 1, registered write enable to the register bank.
- wr_addr, out, ADDR_W, registered write address.
- wr_data, out, DATA_W, registered write data.
- wr_src, out, $clog2(NUM_REQ) (min 1), index of the requester that produced the current strobe.
- addr_err, out, 1, one-cycle pulse: accepted request had addr >= NUM_REGS.

Behaviour:
- Reset (async, rst=1): rr_ptr=0, wr_en=0, wr_addr=0, wr_data=0, wr_src=0, addr_err=0, lock state cleared; req_ready=0 while rst=1.
- Arbitration is combinational within the cycle.
  - Search req_valid starting at index rr_ptr, ascending, wrapping modulo NUM_REQ; the first valid index i wins.
  - req_ready[i]=1 and all other ready bits are 0.
  - No valid request: req_ready=0.
  - req_ready never asserts for a requester whose valid is low.
- On a handshake at edge T:
  - rr_ptr <= (i+1) mod NUM_REQ (NUM_REQ-1 wraps to 0).
  - wr_addr/wr_data/wr_src capture requester i's fields; wr_en <= 1 if addr < NUM_REGS, else wr_en <= 0 and addr_err <= 1.
- Latency: strobe is visible in the cycle after the handshake; the bank updates at the following edge. Throughput is 1 write/cycle.
- No handshake in a cycle: wr_en <= 0, addr_err <= 0; wr_addr/wr_data/wr_src hold their last values.
- Requesters must hold valid/addr/data stable until ready. Dropping valid before ready is legal; the request is simply lost.
- All requesters continuously valid: grants rotate 0,1,...,NUM_REQ-1,0; worst-case wait is NUM_REQ-1 cycles.
- Simultaneous requests to the same address on different cycles: the later grant wins (last write wins in the bank).
- Reset mid-operation: a pending strobe is discarded (wr_en forced 0); no write reaches the bank after rst rises.

Optional Feature:
- Macro: REG_ARB_LOCK_EN.
- Defined:
  - A handshake by requester i with req_lock[i]=1 sets locked=1, owner=i.
  - While locked, only the owner can receive ready; others see ready=0 regardless of valid. rr_ptr is not advanced.
  - The owner's handshake with req_lock[owner]=0 performs that write, clears locked, and sets rr_ptr <= owner+1.
  - The owner dropping valid does not release the lock (owner is responsible for releasing it).
  - Used for atomic multi-register updates.
- Undefined: req_lock is ignored (may be left unconnected/tied 0); pure round-robin; no lock state flops.

Test Plan:
- Reset, then req_valid=4'b0010, addr=3, data=8'hA5 -> req_ready=4'b0010 same cycle; next cycle wr_en=1, wr_addr=3, wr_data=8'hA5, wr_src=1; following cycle wr_en=0.
- req_valid=4'b1111 held for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; wr_en=1 every cycle after the first.
- NUM_REGS=6: requester 2 writes addr=7 -> handshake completes, wr_en=0, addr_err=1 for one cycle, wr_addr=7; rr_ptr advances to 3.
- rr_ptr=3, req_valid=4'b1001 -> requester 3 granted first, then 0; rr_ptr wraps to 0 and then 1.
- Assert rst in the cycle after a handshake -> wr_en=0 immediately (async); after release, rr_ptr=0 and outputs all zero.
- REG_ARB_LOCK_EN, all valid:
  - Requester 1 handshakes with lock=1 -> requesters 0/2/3 see ready=0 for 3 consecutive cycles; requester 1 writes addrs 0,1,2.
  - Its lock=0 handshake releases the lock; the next grant goes to requester 2.
